// File: rtl/commit_trace_pkg.sv
// Shared types and constants for the commit trace unit: packet type codes,
// packet width, FSM state encoding and the packet packing helper.
package commit_trace_pkg;

  localparam logic [1:0] TRC_REG = 2'b01;
  localparam logic [1:0] TRC_MEM = 2'b10;
  localparam int         TRC_W   = 98;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic [TRC_W-1:0] make_pkt(input logic [1:0]  kind,
                                                input logic [31:0] pc,
                                                input logic [31:0] addr,
                                                input logic [31:0] data);
    return {kind, pc, addr, data};
  endfunction

endpackage

// File: rtl/commit_trace_if.sv
// Trace packet stream: {type[97:96], pc[95:64], addr[63:32], data[31:0]}.
// A packet transfers on a clock edge where trc_valid && trc_ready; while
// trc_valid is high and trc_ready low, trc_data holds and trc_valid stays up.
interface commit_trace_if;
  import commit_trace_pkg::*;

  logic             trc_valid;
  logic             trc_ready;
  logic [TRC_W-1:0] trc_data;

  modport master (output trc_valid, output trc_data, input trc_ready);
  modport slave  (input trc_valid, input trc_data, output trc_ready);

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with registered storage; pointers carry one extra wrap bit.
// A push while full is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 98
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/commit_trace_unit.sv
// Retirement monitor: packs register-write and store commits into a trace FIFO,
// ends capture on the end-sign store or MAX_CYCLES, drains, then raises done.
// Build option TRACE_X0_FILTER_EN: register writes to x0 are ignored entirely.
module commit_trace_unit
  import commit_trace_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter int          MAX_CYCLES = 2000,
  parameter logic [31:0] END_ADDR   = 32'h0000_0290,
  parameter logic [31:0] END_DATA   = 32'h7FFF_FFFF,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cpu_pc,
  input  logic              cpu_reg_we,
  input  logic [4:0]        cpu_rd,
  input  logic [31:0]       cpu_wb_data,
  input  logic              cpu_mem_we,
  input  logic [31:0]       cpu_mem_addr,
  input  logic [31:0]       cpu_mem_wdata,
  commit_trace_if.master    trc,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [31:0]       commit_cnt,
  output state_t            state
);

  state_t           state_n;
  logic             capture;
  logic             reg_ev;
  logic             mem_ev;
  logic             push;
  logic             pop;
  logic             accept;
  logic             full;
  logic             empty;
  logic             end_sign;
  logic             timeout_hit;
  logic [TRC_W-1:0] pkt;
  logic [1:0]       n_drop;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_next;
  logic [31:0]      cyc_cnt;

  assign capture = (state == S_RUN);

`ifdef TRACE_X0_FILTER_EN
  assign reg_ev = capture && cpu_reg_we && (cpu_rd != 5'd0);
`else
  assign reg_ev = capture && cpu_reg_we;
`endif
  assign mem_ev = capture && cpu_mem_we;

  // A simultaneous register write loses to the store and is counted as dropped.
  assign push   = reg_ev || mem_ev;
  assign pkt    = mem_ev ? make_pkt(TRC_MEM, cpu_pc, cpu_mem_addr, cpu_mem_wdata)
                         : make_pkt(TRC_REG, cpu_pc, {27'b0, cpu_rd}, cpu_wb_data);
  assign pop    = trc.trc_valid && trc.trc_ready;
  assign accept = push && (!full || pop);
  assign n_drop = {1'b0, push && !accept} + {1'b0, reg_ev && mem_ev};

  assign end_sign    = mem_ev && (cpu_mem_addr == END_ADDR) && (cpu_mem_wdata == END_DATA);
  assign timeout_hit = capture && !end_sign && (cyc_cnt == 32'(MAX_CYCLES - 1));

  assign drop_sum  = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);
  assign drop_next = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(TRC_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (pkt),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .rdata (trc.trc_data)
  );

  assign trc.trc_valid = !empty;
  assign done          = (state == S_DONE);

  always_comb begin
    state_n = state;
    case (state)
      S_RUN:   if (end_sign || timeout_hit) state_n = S_DRAIN;
      S_DRAIN: if (empty) state_n = S_DONE;
      S_DONE:  state_n = S_DONE;
      default: state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_RUN;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc_cnt    <= '0;
      timeout    <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      commit_cnt <= '0;
    end else begin
      if (capture)        cyc_cnt    <= cyc_cnt + 32'd1;
      if (timeout_hit)    timeout    <= 1'b1;
      if (n_drop != 2'd0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_next;
      end
      if (accept)         commit_cnt <= commit_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_commit_trace_unit.sv
// Bench for commit_trace_unit: directed scenarios plus randomized commits,
// every cycle compared against a queue-based reference model.
module tb_commit_trace_unit;
  import commit_trace_pkg::*;

  localparam int          DEPTH    = 16;
  localparam int          MAXC     = 50;
  localparam int          CNT_W    = 16;
  localparam logic [31:0] END_ADDR = 32'h0000_0290;
  localparam logic [31:0] END_DATA = 32'h7FFF_FFFF;
`ifdef TRACE_X0_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [31:0]       cpu_pc;
  logic              cpu_reg_we;
  logic [4:0]        cpu_rd;
  logic [31:0]       cpu_wb_data;
  logic              cpu_mem_we;
  logic [31:0]       cpu_mem_addr;
  logic [31:0]       cpu_mem_wdata;
  logic              trc_ready;
  logic              done;
  logic              timeout;
  logic              overflow;
  logic [CNT_W-1:0]  drop_cnt;
  logic [31:0]       commit_cnt;
  state_t            state;

  commit_trace_if trc_if ();
  assign trc_if.trc_ready = trc_ready;

  commit_trace_unit #(
    .DEPTH(DEPTH), .MAX_CYCLES(MAXC), .END_ADDR(END_ADDR),
    .END_DATA(END_DATA), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .cpu_pc(cpu_pc), .cpu_reg_we(cpu_reg_we),
    .cpu_rd(cpu_rd), .cpu_wb_data(cpu_wb_data), .cpu_mem_we(cpu_mem_we),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata), .trc(trc_if),
    .done(done), .timeout(timeout), .overflow(overflow), .drop_cnt(drop_cnt),
    .commit_cnt(commit_cnt), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected packet queue plus the observable status.
  logic [TRC_W-1:0] exp_q[$];
  state_t           m_state;
  int               m_cyc;
  bit               m_timeout;
  bit               m_overflow;
  longint           m_drop;
  logic [31:0]      m_commit;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit               pop;
    bit               reg_e;
    bit               mem_e;
    int               room;
    int               drops;
    logic [TRC_W-1:0] newp[$];
    if (!reset) begin
      exp_q.delete();
      m_state = S_RUN; m_cyc = 0; m_timeout = 0; m_overflow = 0;
      m_drop = 0; m_commit = '0;
      return;
    end
    pop   = (exp_q.size() != 0) && trc_ready;
    drops = 0;
    case (m_state)
      S_RUN: begin
        reg_e = cpu_reg_we && !(FILT && cpu_rd == 5'd0);
        mem_e = cpu_mem_we;
        room  = DEPTH - exp_q.size() + (pop ? 1 : 0);
        if (mem_e) begin
          if (room > 0) begin
            newp.push_back({2'b10, cpu_pc, cpu_mem_addr, cpu_mem_wdata});
            room--;
          end else drops++;
        end
        if (reg_e) begin
          if (mem_e) drops++;
          else if (room > 0) newp.push_back({2'b01, cpu_pc, 27'd0, cpu_rd, cpu_wb_data});
          else drops++;
        end
        if (mem_e && cpu_mem_addr == END_ADDR && cpu_mem_wdata == END_DATA) m_state = S_DRAIN;
        else if (m_cyc == MAXC - 1) begin
          m_state   = S_DRAIN;
          m_timeout = 1;
        end
        m_cyc++;
      end
      S_DRAIN: if (exp_q.size() == 0) m_state = S_DONE;
      default: ;
    endcase
    if (pop) void'(exp_q.pop_front());
    foreach (newp[i]) exp_q.push_back(newp[i]);
    m_commit += 32'(newp.size());
    if (drops != 0) begin
      m_overflow = 1;
      m_drop     = m_drop + drops;
      if (m_drop > (2**CNT_W - 1)) m_drop = 2**CNT_W - 1;
    end
  endtask

  task automatic compare_all();
    check("valid", trc_if.trc_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("data", trc_if.trc_data, exp_q[0]);
    check("done", done, m_state == S_DONE);
    check("timeout", timeout, m_timeout);
    check("overflow", overflow, m_overflow);
    check("drop_cnt", drop_cnt, m_drop);
    check("commit_cnt", commit_cnt, m_commit);
    check("state", state, m_state);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cpu_reg_we = 0; cpu_mem_we = 0; cpu_rd = '0; cpu_wb_data = '0;
    cpu_mem_addr = '0; cpu_mem_wdata = '0; cpu_pc = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    idle();
    step();
    reset = 1;
  endtask

  task automatic store(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
    idle();
    cpu_pc = pc; cpu_mem_we = 1; cpu_mem_addr = addr; cpu_mem_wdata = data;
    step();
  endtask

  task automatic regw(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
    idle();
    cpu_pc = pc; cpu_reg_we = 1; cpu_rd = rd; cpu_wb_data = data;
    step();
  endtask

  initial begin
    trc_ready = 1;
    reset     = 0;
    idle();
    step();
    do_reset();
    check("rst_valid", trc_if.trc_valid, 1'b0);
    check("rst_commit", commit_cnt, 32'd0);

    // Single register write, one-cycle latency.
    regw(32'h10, 5'd5, 32'h7);
    check("rw_data", trc_if.trc_data, {2'b01, 32'h10, 32'h5, 32'h7});
    check("rw_commit", commit_cnt, 32'd1);
    idle(); step();

    // Overflow with the consumer stalled.
    do_reset();
    trc_ready = 0;
    for (int i = 0; i < 20; i++) store(32'h100 + 4*i, 32'h1000 + 4*i, 32'(i));
    check("ovf_flag", overflow, 1'b1);
    check("ovf_drops", drop_cnt, 16'd4);
    check("ovf_commit", commit_cnt, 32'd16);
    trc_ready = 1;
    idle();
    for (int i = 0; i < 17; i++) step();
    check("ovf_drained", trc_if.trc_valid, 1'b0);

    // Full FIFO: push and pop in the same cycle.
    do_reset();
    trc_ready = 0;
    for (int i = 0; i < 16; i++) store(32'h200 + 4*i, 32'h2000 + 4*i, 32'hA0 + 32'(i));
    trc_ready = 1;
    store(32'h300, 32'h3000, 32'hBEEF);
    check("full_pp_drops", drop_cnt, 16'd0);
    check("full_pp_commit", commit_cnt, 32'd17);

    // End sign with three packets queued; later strobes are ignored.
    do_reset();
    trc_ready = 0;
    for (int i = 0; i < 3; i++) regw(32'h40 + 4*i, 5'(i + 1), 32'(i + 100));
    store(32'h4C, END_ADDR, END_DATA);
    for (int i = 0; i < 3; i++) regw(32'h50, 5'd9, 32'h55);
    trc_ready = 1;
    idle();
    for (int i = 0; i < 10 && !done; i++) step();
    check("end_commit", commit_cnt, 32'd4);
    check("end_done", done, 1'b1);
    check("end_timeout", timeout, 1'b0);

    // Timeout with no end sign.
    do_reset();
    for (int i = 0; i < MAXC; i++) step();
    check("to_flag", timeout, 1'b1);
    step();
    check("to_done", done, 1'b1);

    // End sign in the very last capture cycle wins over timeout.
    do_reset();
    for (int i = 0; i < MAXC - 1; i++) step();
    store(32'h80, END_ADDR, END_DATA);
    check("end_last_to", timeout, 1'b0);
    idle(); step(); step();
    check("end_last_done", done, 1'b1);

    // x0 write.
    do_reset();
    regw(32'h90, 5'd0, 32'h3);
    check("x0_commit", commit_cnt, FILT ? 32'd0 : 32'd1);

    // Reset while draining.
    do_reset();
    trc_ready = 0;
    store(32'hA0, 32'h10, 32'h1);
    store(32'hA4, END_ADDR, END_DATA);
    check("drain_state", state, S_DRAIN);
    do_reset();
    check("drain_rst_valid", trc_if.trc_valid, 1'b0);
    check("drain_rst_done", done, 1'b0);
    check("drain_rst_commit", commit_cnt, 32'd0);
    check("drain_rst_state", state, S_RUN);

    // Randomized runs with varying consumer back-pressure.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int c = 0; c < 150 && m_state != S_DONE; c++) begin
        cpu_pc        = $urandom;
        cpu_reg_we    = 1'($urandom_range(0, 1));
        cpu_rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        cpu_wb_data   = $urandom;
        cpu_mem_we    = ($urandom_range(0, 2) == 0);
        cpu_mem_addr  = $urandom;
        cpu_mem_wdata = $urandom;
        if ($urandom_range(0, 39) == 0) begin
          cpu_mem_we = 1; cpu_mem_addr = END_ADDR; cpu_mem_wdata = END_DATA;
        end
        trc_ready = (c >= MAXC) ? 1'b1 : ($urandom_range(0, 3) < (r % 4));
        step();
      end
      check("rand_done", done, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_trace_unit.md
Name: commit_trace_unit

Overview:
- Hardware retirement monitor that sits directly downstream of the single-cycle RV32I core's writeback and store ports.
- Captures every register write and memory write commit into a trace FIFO and streams the packets out over a valid/ready interface.
- Detects the program end sign (a store of 0x7FFF_FFFF to word 164) or a cycle timeout, drains the FIFO, then raises done.
- Replaces simulation-only trace logging so the same trace can be taken from FPGA or emulation.

Parameters:
- DEPTH, 16, trace FIFO entries; must be a power of 2, minimum 2.
- MAX_CYCLES, 2000, number of capture cycles before timeout.
- END_ADDR, 32'h0000_0290, byte address of the end-sign store (word 164).
- END_DATA, 32'h7FFF_FFFF, end-sign store data.
- CNT_W, 16, width of drop_cnt.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-low.
- cpu_pc  in  32  PC of the committing instruction.
- cpu_reg_we  in  1  register-write strobe (core RegWrite).
- cpu_rd  in  5  destination register index (instr[11:7]).
- cpu_wb_data  in  32  writeback data.
- cpu_mem_we  in  1  store strobe (core MemWrite).
- cpu_mem_addr  in  32  store byte address (ALU output).
- cpu_mem_wdata  in  32  store data (rs2 value).
- trc_valid  out  1  trace packet available.
- trc_ready  in  1  consumer accepts packet.
- trc_data  out  98  packet: {type[97:96], pc[95:64], addr[63:32], data[31:0]}.
- done  out  1  capture finished and FIFO drained.
- timeout  out  1  finished by MAX_CYCLES, not by end sign.
- overflow  out  1  sticky: at least one event was dropped.
- drop_cnt  out  CNT_W  number of dropped events, saturating.
- commit_cnt  out  32  number of accepted packets.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs go to 0, the FIFO is emptied, the cycle counter is cleared, and the state goes to S_RUN.
  - Reset mid-operation discards any queued packets.
- Packet formation (S_RUN only):
  - Register write: cpu_reg_we → type 2'b01, addr={27'b0,cpu_rd}, data=cpu_wb_data.
  - Store: cpu_mem_we → type 2'b10, addr=cpu_mem_addr, data=cpu_mem_wdata.
  - pc=cpu_pc for both.
  - Both strobes in the same cycle (not legal for RV32I): the store is enqueued and the register write is counted as a drop.
- FIFO:
  - A push is accepted if not full, or if a pop happens in the same cycle (full with trc_valid&&trc_ready).
  - A push that is not accepted is dropped: overflow←1, drop_cnt+1, saturating at all-ones.
  - Each accepted push increments commit_cnt, which wraps.
  - Event at edge N → trc_valid=1 after edge N (1-cycle latency) when the FIFO was empty.
  - trc_valid=!empty. trc_data holds stable while trc_valid && !trc_ready.
  - Pop on trc_valid&&trc_ready. Packets leave in strict arrival order.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- FSM:
  - S_RUN: capture is on and the cycle counter increments every cycle.
    - A store with addr==END_ADDR and data==END_DATA → S_DRAIN. That packet is enqueued if space allows.
    - Otherwise, when the counter reaches MAX_CYCLES-1 → S_DRAIN with timeout←1.
    - End sign and timeout in the same cycle: end sign wins, timeout stays 0.
  - S_DRAIN: capture is off (strobes ignored, not counted as drops) and the FIFO keeps emptying. When empty → S_DONE.
  - S_DONE: done=1 and held. Only reset leaves this state.
- If the end-sign store arrives when the FIFO is full, it is dropped (overflow set) but still ends capture.

Optional Feature:
- Macro: TRACE_X0_FILTER_EN.
- Defined: register writes with cpu_rd==0 are ignored. They produce no packet, no drop, and no commit_cnt increment.
- Undefined: x0 writes are traced like any other register write.

Decomposition:
- Package commit_trace_pkg holds:
  - Type codes TRC_REG=2'b01 and TRC_MEM=2'b10.
  - TRC_W=98.
  - FSM state encoding S_RUN, S_DRAIN, S_DONE.
- Sub-module trace_fifo(DEPTH, WIDTH): synchronous FIFO with full/empty and registered storage. The top level holds the FSM, packet mux, and counters.

Test Plan:
- Register write: pc=0x10, rd=5, wb=7, ready=1 → next cycle trc_valid=1, trc_data={01,0x10,0x5,0x7}, commit_cnt=1.
- Overflow: ready=0 with 20 back-to-back stores, DEPTH=16 → overflow=1, drop_cnt=4, commit_cnt=16. Raise ready → the 16 packets come out in order, then trc_valid=0.
- At full, push and pop in the same cycle → push accepted, drop_cnt unchanged.
- End sign with 3 packets queued: store 0x7FFF_FFFF to 0x290 → later strobes ignored, 4 packets out, done=1 the cycle after the last pop, timeout=0.
- Timeout: MAX_CYCLES=50, no end sign → timeout=1 at cycle 50, done after drain. End sign exactly at cycle 49 → timeout=0.
- x0 write (rd=0, wb=3) → no packet with TRACE_X0_FILTER_EN defined, one packet without it.
- Reset: reset low during S_DRAIN → next cycle trc_valid=0, done=0, all counters 0, state S_RUN.
